// File: rtl/context_switch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : context_switch_controller_pkg
// Description : Shared stage encodings for the decoder controller, the
//               context-switch controller and the edge/PE array.
//               Exports: STAGE_WIDTH and the STAGE_* stage codes.
// Revision    : 1.0 - initial release
// ============================================================================
package context_switch_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEEL                = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM        = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM       = 3'd6;

endpackage
`default_nettype wire

// File: rtl/context_switch_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : context_switch_controller_if
// Description : Request / broadcast bundle of the context-switch controller.
//               master : controller view (takes request + upstream stage,
//                        drives ready, global stage, local flag, context,
//                        done pulse)
//               slave  : main-controller / array view (mirror of master)
//               CTX_WIDTH must match the controller's CTX_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
interface context_switch_controller_if
  import context_switch_controller_pkg::*;
#(
  parameter int CTX_WIDTH = 1
) ();

  logic [STAGE_WIDTH-1:0] upstream_stage;
  logic                   ctx_req_valid;
  logic                   ctx_req_local;
  logic                   ctx_req_ready;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   local_context_switch;
  logic [CTX_WIDTH-1:0]   current_context;
  logic                   ctx_done;

  modport master (
    input  upstream_stage,
    input  ctx_req_valid,
    input  ctx_req_local,
    output ctx_req_ready,
    output global_stage,
    output local_context_switch,
    output current_context,
    output ctx_done
  );

  modport slave (
    output upstream_stage,
    output ctx_req_valid,
    output ctx_req_local,
    input  ctx_req_ready,
    input  global_stage,
    input  local_context_switch,
    input  current_context,
    input  ctx_done
  );

endinterface
`default_nettype wire

// File: rtl/context_switch_controller_ctx_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : ctx_wrap_counter
// Description : Modulo-NUM_CONTEXTS counter with enable. Same stepping rule
//               as the edge memory address, so the two stay in lockstep.
//               clk   in  clock
//               reset in  synchronous, active-high (count -> 0)
//               en    in  advance by one (wrapping to 0 after NUM_CONTEXTS-1)
//               count out current index
// Revision    : 1.0 - initial release
// ============================================================================
module ctx_wrap_counter #(
  parameter int NUM_CONTEXTS = 2,
  parameter int CTX_WIDTH    = 1
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 en,
  output logic      [CTX_WIDTH-1:0] count
);

  // With a single context the last index is 0, so every advance wraps to 0.
  localparam logic [CTX_WIDTH-1:0] c_LAST =
    CTX_WIDTH'(NUM_CONTEXTS > 1 ? NUM_CONTEXTS - 1 : 0);

  logic [CTX_WIDTH-1:0] r_count;
  logic [CTX_WIDTH-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (en) begin
      w_count_next = (r_count == c_LAST) ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/context_switch_controller.sv
`default_nettype none
// ============================================================================
// Module      : context_switch_controller
// Description : Initiator of the edge/PE context-switch protocol. In IDLE the
//               upstream stage is passed to the array one cycle late. An
//               accepted request sequences the broadcast stage through
//               WRITE_TO_MEM, a memory-settle gap (non-local only) and
//               READ_FROM_MEM, then pulses ctx_done.
//               clk     in  clock
//               reset   in  synchronous, active-high
//               ctx_if  master modport:
//                 upstream_stage, ctx_req_valid, ctx_req_local (in)
//                 ctx_req_ready, global_stage, local_context_switch,
//                 current_context, ctx_done (out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module context_switch_controller
  import context_switch_controller_pkg::*;
#(
  parameter int NUM_CONTEXTS     = 2,
  parameter int MEM_READ_LATENCY = 2,
  parameter int CTX_WIDTH        = $clog2(NUM_CONTEXTS > 1 ? NUM_CONTEXTS : 2)
) (
  input wire logic                   clk,
  input wire logic                   reset,
  context_switch_controller_if.master ctx_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int                    c_WAIT_W    = $clog2(MEM_READ_LATENCY + 1);
  // WAIT lasts MEM_READ_LATENCY cycles and exits when the counter is 0.
  localparam logic [c_WAIT_W-1:0]   c_WAIT_LOAD = c_WAIT_W'(MEM_READ_LATENCY - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [c_WAIT_W-1:0]    r_wait_cnt;
  logic [c_WAIT_W-1:0]    w_wait_cnt_next;
  logic                   r_local;
  logic                   w_local_next;
  logic [STAGE_WIDTH-1:0] r_stage;
  logic [STAGE_WIDTH-1:0] w_stage_next;
  logic                   r_ready;
  logic                   r_done;
  logic                   w_ctx_advance;
  logic [CTX_WIDTH-1:0]   w_ctx;

  // The edge address advances while the array sees WRITE_TO_MEM; the
  // controller's copy steps during WRITE so it reads the new index from the
  // cycle after WRITE onwards.
  assign w_ctx_advance = (r_state == S_WRITE) && !r_local;

  ctx_wrap_counter #(
    .NUM_CONTEXTS (NUM_CONTEXTS),
    .CTX_WIDTH    (CTX_WIDTH)
  ) u_ctx_counter (
    .clk   (clk),
    .reset (reset),
    .en    (w_ctx_advance),
    .count (w_ctx)
  );

  // Next state plus the next value of every registered output. Outputs are
  // computed from the state being entered so they line up with it.
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_local_next    = r_local;
    w_stage_next    = STAGE_IDLE;

    case (r_state)
      S_IDLE: begin
        w_stage_next = ctx_if.upstream_stage;
        if (ctx_if.ctx_req_valid) begin
          w_state_next = S_WRITE;
          w_local_next = ctx_if.ctx_req_local;
          w_stage_next = STAGE_WRITE_TO_MEM;
        end
      end
      S_WRITE: begin
        if (r_local) begin
          // Local switch: no address change, so no settle gap.
          w_state_next = S_READ;
          w_stage_next = STAGE_READ_FROM_MEM;
        end else begin
          w_state_next    = S_WAIT;
          w_wait_cnt_next = c_WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_next = S_READ;
          w_stage_next = STAGE_READ_FROM_MEM;
        end else begin
          w_wait_cnt_next = r_wait_cnt - 1'b1;
        end
      end
      S_READ: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        // Local flag is held through DONE because the edges compare it with
        // their one-cycle-late stage copy; it drops as IDLE is entered.
        w_state_next = S_IDLE;
        w_local_next = 1'b0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_local_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_local    <= 1'b0;
      r_stage    <= STAGE_IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_local    <= w_local_next;
      r_stage    <= w_stage_next;
      r_ready    <= (w_state_next == S_IDLE);
      r_done     <= (w_state_next == S_DONE);
    end
  end

  assign ctx_if.ctx_req_ready        = r_ready;
  assign ctx_if.global_stage         = r_stage;
  assign ctx_if.local_context_switch = r_local;
  assign ctx_if.current_context      = w_ctx;
  assign ctx_if.ctx_done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_context_switch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_context_switch_controller
// Description : Directed bench for context_switch_controller. Instance A uses
//               NUM_CONTEXTS=2 / latency 2 and drives a small edge model that
//               saves and restores {is_error, growth} per context. Instance B
//               uses NUM_CONTEXTS=3 / latency 1 to exercise the index wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_context_switch_controller;
  import context_switch_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  context_switch_controller_if #(.CTX_WIDTH(1)) bus_a ();
  context_switch_controller_if #(.CTX_WIDTH(2)) bus_b ();

  context_switch_controller #(
    .NUM_CONTEXTS     (2),
    .MEM_READ_LATENCY (2),
    .CTX_WIDTH        (1)
  ) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .ctx_if (bus_a.master)
  );

  context_switch_controller #(
    .NUM_CONTEXTS     (3),
    .MEM_READ_LATENCY (1),
    .CTX_WIDTH        (2)
  ) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .ctx_if (bus_b.master)
  );

  // Edge model: reacts to its lagged stage copy, skipped on local switches.
  logic [STAGE_WIDTH-1:0] edge_stage_d;
  logic                   edge_addr;
  logic [4:0]             edge_mem [0:1];
  logic [4:0]             edge_live;
  logic                   set_en;
  logic [4:0]             set_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_stage_d <= STAGE_IDLE;
      edge_addr    <= 1'b0;
      edge_live    <= 5'd0;
      edge_mem[0]  <= 5'd0;
      edge_mem[1]  <= 5'd0;
    end else begin
      edge_stage_d <= bus_a.global_stage;
      if (set_en) begin
        edge_live <= set_val;
      end else if (edge_stage_d == STAGE_READ_FROM_MEM && !bus_a.local_context_switch) begin
        edge_live <= edge_mem[edge_addr];
      end
      if (edge_stage_d == STAGE_WRITE_TO_MEM && !bus_a.local_context_switch) begin
        edge_mem[edge_addr] <= edge_live;
        edge_addr           <= edge_addr + 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [4:0] v);
    set_en  = 1'b1;
    set_val = v;
    step();
    set_en  = 1'b0;
  endtask

  // One request on instance A, bounded wait for ctx_done, then one cycle so
  // the edge model has applied its restore.
  task automatic do_switch(input logic loc);
    int n;
    bus_a.ctx_req_valid = 1'b1;
    bus_a.ctx_req_local = loc;
    step();
    bus_a.ctx_req_valid = 1'b0;
    n = 0;
    while (bus_a.ctx_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("switch done seen", 32'(bus_a.ctx_done), 32'd1);
    step();
  endtask

  typedef struct {
    logic [STAGE_WIDTH-1:0] up;
    logic                   valid;
    logic                   loc;
    logic [STAGE_WIDTH-1:0] e_stage;
    logic                   e_ready;
    logic                   e_lcs;
    logic                   e_ctx;
    logic                   e_done;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Row i: inputs held during one cycle, expected outputs after the edge.
    vecs[0]  = '{STAGE_MEASUREMENT_LOADING, 1'b0, 1'b0, STAGE_MEASUREMENT_LOADING, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{STAGE_IDLE,  1'b1, 1'b0, STAGE_WRITE_TO_MEM,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{STAGE_MERGE, 1'b0, 1'b0, STAGE_IDLE,          1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{STAGE_MERGE, 1'b0, 1'b0, STAGE_IDLE,          1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{STAGE_MERGE, 1'b0, 1'b0, STAGE_READ_FROM_MEM, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{STAGE_MERGE, 1'b0, 1'b0, STAGE_IDLE,          1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{STAGE_IDLE,  1'b0, 1'b0, STAGE_IDLE,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{STAGE_GROW,  1'b0, 1'b0, STAGE_GROW,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{STAGE_IDLE,  1'b1, 1'b1, STAGE_WRITE_TO_MEM,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{STAGE_IDLE,  1'b0, 1'b0, STAGE_READ_FROM_MEM, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{STAGE_IDLE,  1'b0, 1'b0, STAGE_IDLE,          1'b0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{STAGE_IDLE,  1'b0, 1'b0, STAGE_IDLE,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{STAGE_PEEL,  1'b0, 1'b0, STAGE_PEEL,          1'b1, 1'b0, 1'b1, 1'b0};

    reset                = 1'b1;
    set_en               = 1'b0;
    set_val              = 5'd0;
    bus_a.upstream_stage = STAGE_IDLE;
    bus_a.ctx_req_valid  = 1'b0;
    bus_a.ctx_req_local  = 1'b0;
    bus_b.upstream_stage = STAGE_IDLE;
    bus_b.ctx_req_valid  = 1'b0;
    bus_b.ctx_req_local  = 1'b0;
    step();
    step();

    check("reset stage", 32'(bus_a.global_stage),         32'(STAGE_IDLE));
    check("reset ready", 32'(bus_a.ctx_req_ready),        32'd1);
    check("reset lcs",   32'(bus_a.local_context_switch), 32'd0);
    check("reset ctx",   32'(bus_a.current_context),      32'd0);
    check("reset done",  32'(bus_a.ctx_done),             32'd0);
    reset = 1'b0;

    // Pass-through, one non-local switch, one local switch.
    for (int i = 0; i < 13; i++) begin
      bus_a.upstream_stage = vecs[i].up;
      bus_a.ctx_req_valid  = vecs[i].valid;
      bus_a.ctx_req_local  = vecs[i].loc;
      step();
      check($sformatf("vec%0d stage", i), 32'(bus_a.global_stage),         32'(vecs[i].e_stage));
      check($sformatf("vec%0d ready", i), 32'(bus_a.ctx_req_ready),        32'(vecs[i].e_ready));
      check($sformatf("vec%0d lcs", i),   32'(bus_a.local_context_switch), 32'(vecs[i].e_lcs));
      check($sformatf("vec%0d ctx", i),   32'(bus_a.current_context),      32'(vecs[i].e_ctx));
      check($sformatf("vec%0d done", i),  32'(bus_a.ctx_done),             32'(vecs[i].e_done));
    end
    bus_a.upstream_stage = STAGE_IDLE;
    step();

    // Lockstep with the edge model; live state restored per context.
    check("edge addr lockstep 0", 32'(edge_addr), 32'(bus_a.current_context));
    set_live(5'h0A);
    do_switch(1'b0);
    check("ctx after sw1",  32'(bus_a.current_context), 32'd0);
    check("addr after sw1", 32'(edge_addr),             32'd0);
    check("live after sw1", 32'(edge_live),             32'h00);
    set_live(5'h13);
    do_switch(1'b0);
    check("ctx after sw2",  32'(bus_a.current_context), 32'd1);
    check("live after sw2", 32'(edge_live),             32'h0A);
    do_switch(1'b0);
    check("ctx after sw3",  32'(bus_a.current_context), 32'd0);
    check("live after sw3", 32'(edge_live),             32'h13);
    do_switch(1'b1);
    check("ctx after local",  32'(bus_a.current_context), 32'd0);
    check("live after local", 32'(edge_live),             32'h13);
    check("addr after local", 32'(edge_addr),             32'd0);

    // Reset during WAIT aborts to reset values with no done pulse.
    bus_a.ctx_req_valid = 1'b1;
    bus_a.ctx_req_local = 1'b0;
    step();
    bus_a.ctx_req_valid = 1'b0;
    step();
    check("pre-abort ctx",   32'(bus_a.current_context), 32'd1);
    check("pre-abort stage", 32'(bus_a.global_stage),    32'(STAGE_IDLE));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort stage", 32'(bus_a.global_stage),    32'(STAGE_IDLE));
    check("abort ready", 32'(bus_a.ctx_req_ready),   32'd1);
    check("abort ctx",   32'(bus_a.current_context), 32'd0);
    check("abort done",  32'(bus_a.ctx_done),        32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("abort quiet done c%0d", c), 32'(bus_a.ctx_done), 32'd0);
    end

    // Valid held high: a new switch every 4+L = 6 cycles.
    bus_a.ctx_req_valid = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      int k;
      step();
      k = (c >= 2) ? ((c - 2) / 6 + 1) : 0;
      check($sformatf("held c%0d ready", c), 32'(bus_a.ctx_req_ready),   32'((c % 6) == 0));
      check($sformatf("held c%0d done", c),  32'(bus_a.ctx_done),        32'((c % 6) == 5));
      check($sformatf("held c%0d ctx", c),   32'(bus_a.current_context), 32'(k % 2));
    end
    bus_a.ctx_req_valid = 1'b0;

    // Instance B: three contexts, latency 1, period 5, index wraps 2 -> 0.
    bus_b.ctx_req_valid = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      int k;
      logic [STAGE_WIDTH-1:0] es;
      step();
      k  = (c >= 2) ? ((c - 2) / 5 + 1) : 0;
      es = ((c % 5) == 1) ? STAGE_WRITE_TO_MEM :
           ((c % 5) == 3) ? STAGE_READ_FROM_MEM : STAGE_IDLE;
      check($sformatf("b c%0d stage", c), 32'(bus_b.global_stage),    32'(es));
      check($sformatf("b c%0d done", c),  32'(bus_b.ctx_done),        32'((c % 5) == 4));
      check($sformatf("b c%0d ctx", c),   32'(bus_b.current_context), 32'(k % 3));
    end
    bus_b.ctx_req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
